// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the nibble-serial adder controller.
package serial_add_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Index width for n nibble passes, never narrower than one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/nibble_add_slice.sv
// Combinational 4-bit ripple-carry adder slice with carry-in.
module nibble_add_slice
    import serial_add_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic [NIBBLE_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
        logic p;
        assign p        = a[i] ^ b[i];
        assign sum[i]   = p ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (p & c[i]);
    end

    assign cout = c[NIBBLE_W];

endmodule

// File: rtl/serial_add_ctrl.sv
// Nibble-serial add/accumulate controller: one shared 4-bit slice, LSB nibble first,
// carry registered between passes, valid/ready on both sides.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_acc,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int unsigned NIB   = WIDTH / NIBBLE_W;
    localparam int unsigned IDX_W = clog2(NIB);

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic                carry;
    logic [WIDTH-1:0]    acc;
    logic [WIDTH-1:0]    op_a;
    logic [WIDTH-1:0]    op_b;
    logic [WIDTH-1:0]    sum;
    logic [WIDTH-1:0]    next_sum;
    logic                cout_q;
    logic [NIBBLE_W-1:0] slice_a;
    logic [NIBBLE_W-1:0] slice_b;
    logic [NIBBLE_W-1:0] slice_sum;
    logic                slice_cout;
    logic                last;

    assign slice_a = op_a[NIBBLE_W*idx +: NIBBLE_W];
    assign slice_b = op_b[NIBBLE_W*idx +: NIBBLE_W];
    assign last    = (idx == IDX_W'(NIB - 1));

    nibble_add_slice u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        next_sum                           = sum;
        next_sum[NIBBLE_W*idx +: NIBBLE_W] = slice_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            acc    <= '0;
            op_a   <= '0;
            op_b   <= '0;
            sum    <= '0;
            cout_q <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    // Clear wins for acc, but an accumulate still latches the old value.
                    if (acc_clr) acc <= '0;
                    if (in_valid) begin
                        op_a  <= in_acc ? acc : in_a;
                        op_b  <= in_b;
                        carry <= 1'b0;
                        idx   <= '0;
                        sum   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum   <= next_sum;
                    carry <= slice_cout;
                    if (last) begin
                        cout_q <= slice_cout;
                        acc    <= next_sum;
                        idx    <= '0;
                        state  <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (acc_clr) acc <= '0;
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign out_valid = (state == S_DONE);
    assign out_sum   = sum;
    assign out_cout  = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=16).
module tb_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_acc;
    logic        acc_clr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_cout;
    logic        busy;

    int vectors = 0;
    int errors  = 0;

    serial_add_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_acc    (in_acc),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one operation for a single accept edge, then scramble the inputs.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                            input logic acc, input logic clr);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("accept_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_acc   = acc;
        acc_clr  = clr;
        tick();
        in_valid = 1'b0;
        acc_clr  = 1'b0;
        in_a     = ~a;
        in_b     = ~b;
        in_acc   = ~acc;
    endtask

    task automatic wait_done(input string tag, input int exp_lat,
                             input logic [15:0] exp_sum, input logic exp_cout);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            chk({tag, "_run_ready"}, {31'd0, in_ready}, 32'd0);
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_sum"}, {16'd0, out_sum}, {16'd0, exp_sum});
        chk({tag, "_cout"}, {31'd0, out_cout}, {31'd0, exp_cout});
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_done_ready"}, {31'd0, in_ready}, 32'd0);
    endtask

    task automatic release_out;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("release_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic acc, input logic [15:0] exp_sum, input logic exp_cout);
        start_op(a, b, acc, 1'b0);
        wait_done(tag, 4, exp_sum, exp_cout);
        release_out();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_acc    = 1'b0;
        acc_clr   = 1'b0;
        out_ready = 1'b0;
        #3;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_sum", {16'd0, out_sum}, 32'd0);
        chk("rst_out_cout", {31'd0, out_cout}, 32'd0);
        #9 rst = 1'b0;
        tick();

        run_op("add_ff_1", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
        run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        run_op("acc_zero", 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0);

        run_op("preload", 16'h5555, 16'h1111, 1'b0, 16'h6666, 1'b0);
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        run_op("acc1", 16'hAAAA, 16'h1234, 1'b1, 16'h1234, 1'b0);
        run_op("acc2", 16'hAAAA, 16'h1111, 1'b1, 16'h2345, 1'b0);
        run_op("acc3", 16'hAAAA, 16'hF000, 1'b1, 16'h1345, 1'b1);

        // Backpressure with a competing request held on the input.
        start_op(16'h0001, 16'h0001, 1'b0, 1'b0);
        wait_done("bp", 4, 16'h0002, 1'b0);
        in_valid = 1'b1;
        in_a     = 16'h7777;
        in_b     = 16'h7777;
        in_acc   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_sum", {16'd0, out_sum}, 32'h0002);
            chk("bp_cout", {31'd0, out_cout}, 32'd0);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("bp_idle_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_idle_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("bp_no_accept", {31'd0, busy}, 32'd0);

        // Reset in the middle of RUN at idx 2.
        start_op(16'h8888, 16'h8888, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_sum", {16'd0, out_sum}, 32'd0);
        chk("mid_rst_cout", {31'd0, out_cout}, 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_rst_no_valid", {31'd0, out_valid}, 32'd0);
        end
        run_op("post_rst_acc", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b0);
        run_op("post_rst_add", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0);

        // acc_clr held through RUN is ignored.
        start_op(16'h0000, 16'h0010, 1'b1, 1'b0);
        acc_clr = 1'b1;
        tick();
        tick();
        tick();
        acc_clr = 1'b0;
        wait_done("run_clr", 1, 16'h0013, 1'b0);
        release_out();
        run_op("run_clr_acc", 16'h0000, 16'h0000, 1'b1, 16'h0013, 1'b0);

        // Clear coincident with an accumulate accept uses the pre-clear value.
        start_op(16'h0000, 16'h0100, 1'b1, 1'b1);
        wait_done("clr_accept", 4, 16'h0113, 1'b0);
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        chk("done_clr_sum", {16'd0, out_sum}, 32'h0113);
        chk("done_clr_valid", {31'd0, out_valid}, 32'd1);
        release_out();
        run_op("done_clr_acc", 16'h0000, 16'h0007, 1'b1, 16'h0007, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
